sram_frame_arbiter: RTL and testbench

- Owns the external 256k x 16 SRAM and sequences every access to it.
- Time-shares the SRAM between two requesters:
  - the display read path, which needs one word per request;
  - the frame-writer pixel stream, which delivers 6-bit pixels of a 100x600 frame in raster order.
- Implements double buffering: a front bank is read by the display, a back bank is written by the frame writer, and the two swap at vertical blank once a complete frame has been written.

---
 rtl/sram_frame_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_sram_frame_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_arbiter.sv
// sram_frame_arbiter
// Owns the external SRAM and sequences every access to it. Display reads
// (one word per request, highest priority) share the SRAM with the
// frame-writer pixel stream. Front/back banks swap at vertical blank once
// the back frame is complete.
module sram_frame_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int PIX_W       = 6,
  parameter int FRAME_WORDS = 60000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vsync_start,
  input  logic                rd_req,
  input  logic [ADDR_W-3:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                wr_req,
  input  logic [PIX_W-1:0]    wr_data,
  output logic                wr_ack,
  output logic                frame_done,
  output logic                front_bank,
  output logic [ADDR_W-1:0]   sram_addr,
  inout  wire  [DATA_W-1:0]   sram_dq,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n
);

  localparam int PTR_W = ADDR_W - 2;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_WORDS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;

  logic [2:0]        r_state;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic              r_front;
  logic              r_back_full;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [2:0]        w_next_state;
  logic              w_ce_n;
  logic              w_oe_n;
  logic              w_we_n;
  logic              w_ub_n;
  logic              w_lb_n;
  logic              w_drive;
  logic              w_wr_ack;
  logic              w_frame_done;
  logic              w_swap;

  // Next-state selection: reads win in IDLE; writes run to completion.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (rd_req)
          w_next_state = S_RD;
        else if (wr_req && !r_back_full)
          w_next_state = S_WR_SETUP;
      end
      S_RD:       w_next_state = S_IDLE;
      S_WR_SETUP: w_next_state = S_WR_PULSE;
      S_WR_PULSE: w_next_state = S_WR_HOLD;
      S_WR_HOLD:  w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // Strobes and bus enable decoded from the state register alone, so an
  // asynchronous reset releases we_n and the bus without a clock edge.
  always_comb begin
    w_ce_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_ub_n  = 1'b1;
    w_lb_n  = 1'b1;
    w_drive = 1'b0;
    case (r_state)
      S_RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_ub_n = 1'b0;
        w_lb_n = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        w_ce_n  = 1'b0;
        w_lb_n  = 1'b0;
        w_drive = 1'b1;
      end
      S_WR_PULSE: begin
        w_ce_n  = 1'b0;
        w_lb_n  = 1'b0;
        w_we_n  = 1'b0;
        w_drive = 1'b1;
      end
      default: begin
        w_ce_n = 1'b1;
      end
    endcase
  end

  // Address and write data are captured when leaving IDLE and held for the
  // whole access, so a bank swap on the edge ending RD cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sram_addr <= '0;
      r_wdata     <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_next_state == S_RD) begin
        r_sram_addr <= {1'b0, r_front, rd_addr};
      end else if (w_next_state == S_WR_SETUP) begin
        r_sram_addr <= {1'b0, ~r_front, r_wr_ptr};
        r_wdata     <= {{(DATA_W-PIX_W){1'b0}}, wr_data};
      end
    end
  end

  assign w_wr_ack     = (r_state == S_WR_HOLD);
  assign w_frame_done = w_wr_ack && (r_wr_ptr == LAST_PTR);
  // A vsync coinciding with the final ack counts the frame as complete.
  assign w_swap       = vsync_start && (r_back_full || w_frame_done);

  // Write pointer, back-buffer status and bank selection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_front     <= 1'b0;
      r_back_full <= 1'b0;
    end else if (w_swap) begin
      r_front     <= ~r_front;
      r_wr_ptr    <= '0;
      r_back_full <= 1'b0;
    end else if (w_frame_done) begin
      r_back_full <= 1'b1;
    end else if (w_wr_ack) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Read data capture on the edge leaving RD, valid pulse the cycle after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= (r_state == S_RD);
      if (r_state == S_RD)
        r_rd_data <= sram_dq;
    end
  end

  assign sram_dq    = w_drive ? r_wdata : 'z;
  assign sram_addr  = r_sram_addr;
  assign sram_ce_n  = w_ce_n;
  assign sram_oe_n  = w_oe_n;
  assign sram_we_n  = w_we_n;
  assign sram_ub_n  = w_ub_n;
  assign sram_lb_n  = w_lb_n;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign wr_ack     = w_wr_ack;
  assign frame_done = w_frame_done;
  assign front_bank = r_front;

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Self-checking bench for sram_frame_arbiter: directed vector table,
// hand-written multi-cycle sequences and a randomized phase checked
// against a transaction-level model of the banks and the frame memory.
module tb_sram_frame_arbiter;

  localparam int FW = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync_start;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_req;
  logic [5:0]  wr_data;
  logic        wr_ack;
  logic        frame_done;
  logic        front_bank;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  always #5 clk = ~clk;

  sram_frame_arbiter #(
    .ADDR_W(18), .DATA_W(16), .PIX_W(6), .FRAME_WORDS(FW)
  ) dut (
    .clk(clk), .rst(rst), .vsync_start(vsync_start),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .frame_done(frame_done), .front_bank(front_bank),
    .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] sram_mem [0:262143];
  logic [15:0] gold     [0:262143];
  logic [15:0] sram_q;

  function automatic logic [15:0] fill(input logic [17:0] a);
    logic [17:0] t;
    t = a * 18'd37 + 18'h00A5C;
    return t[15:0] ^ 16'h5A00;
  endfunction

  always @(negedge clk) begin
    sram_q <= sram_mem[sram_addr];
    if (rst && !sram_ce_n && !sram_we_n)
      sram_mem[sram_addr] = sram_dq;
  end

  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_q : 'z;

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Transaction-level model state
  bit m_front;
  int m_ptr;
  bit m_full;

  task automatic do_read(input logic [15:0] a, input bit vs_in_rd,
                         output logic [15:0] data, output int lat, output int oe_cnt,
                         output logic [17:0] seen_addr, output bit got);
    rd_req = 1'b1; rd_addr = a;
    lat = 0; oe_cnt = 0; got = 0; seen_addr = '0; data = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (vsync_start) vsync_start = 1'b0;
      if (!sram_ce_n && !sram_oe_n) begin
        oe_cnt++; seen_addr = sram_addr;
        if (vs_in_rd) vsync_start = 1'b1;
      end
      if (rd_valid) begin
        data = rd_data; lat = c; got = 1; break;
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] pix, input bit vs_on_ack, input int limit,
                          output bit acked, output logic [17:0] waddr, output logic [15:0] wdq,
                          output int we_cnt, output int ack_at, output logic [3:0] we_pat,
                          output bit done);
    wr_req = 1'b1; wr_data = pix;
    acked = 0; waddr = '0; wdq = '0; we_cnt = 0; ack_at = 0; we_pat = '0; done = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (!sram_ce_n && sram_oe_n) we_pat = {we_pat[2:0], sram_we_n};
      if (!sram_ce_n && !sram_we_n) begin
        we_cnt++; waddr = sram_addr; wdq = sram_dq;
      end
      if (wr_ack) begin
        acked = 1; ack_at = c; done = frame_done;
        if (vs_on_ack) vsync_start = 1'b1;
        break;
      end
    end
    wr_req = 1'b0;
    if (vsync_start) begin
      @(negedge clk);
      vsync_start = 1'b0;
    end
  endtask

  task automatic model_read(input logic [15:0] a, input bit vs, input string tag,
                            output logic [15:0] d, output logic [17:0] sa, output int lat);
    logic [17:0] ea;
    int oe_cnt;
    bit got;
    ea = {1'b0, m_front, a};
    do_read(a, vs, d, lat, oe_cnt, sa, got);
    check({tag, " rd_valid seen"}, 32'(got), 1);
    check({tag, " rd addr"}, 32'(sa), 32'(ea));
    check({tag, " rd data"}, 32'(d), 32'(gold[ea]));
    check({tag, " oe cycles"}, oe_cnt, 1);
    check({tag, " rd latency"}, 32'(lat >= 2 && lat <= 5), 1);
    if (vs && m_full) begin
      m_front = ~m_front; m_ptr = 0; m_full = 0;
    end
    check({tag, " front after rd"}, 32'(front_bank), 32'(m_front));
  endtask

  task automatic model_write(input logic [5:0] pix, input bit vs, input string tag,
                             output logic [17:0] wa, output logic [15:0] wd, output int ack_at);
    logic [17:0] ea;
    bit acked, done, exp_done;
    int we_cnt;
    logic [3:0] pat;
    if (m_full) begin
      do_write(pix, 1'b0, 12, acked, wa, wd, we_cnt, ack_at, pat, done);
      check({tag, " no ack while full"}, 32'(acked), 0);
      check({tag, " no we while full"}, we_cnt, 0);
      return;
    end
    ea = {1'b0, ~m_front, 16'(m_ptr)};
    exp_done = (m_ptr == FW - 1);
    do_write(pix, vs, 20, acked, wa, wd, we_cnt, ack_at, pat, done);
    check({tag, " ack"}, 32'(acked), 1);
    check({tag, " wr addr"}, 32'(wa), 32'(ea));
    check({tag, " wr data"}, 32'(wd), 32'({10'b0, pix}));
    check({tag, " we pulses"}, we_cnt, 1);
    check({tag, " setup/pulse/hold"}, 32'(pat), 32'(4'b0101));
    check({tag, " frame_done"}, 32'(done), 32'(exp_done));
    gold[ea] = {10'b0, pix};
    if (exp_done) begin
      if (vs) begin m_front = ~m_front; m_ptr = 0; m_full = 0; end
      else m_full = 1;
    end else begin
      m_ptr++;
    end
  endtask

  task automatic vsync_pulse(input string tag);
    vsync_start = 1'b1;
    @(negedge clk);
    vsync_start = 1'b0;
    if (m_full) begin m_front = ~m_front; m_ptr = 0; m_full = 0; end
    check({tag, " front_bank"}, 32'(front_bank), 32'(m_front));
  endtask

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [5:0]  pix;
    logic [17:0] exp_addr;
    logic [15:0] exp_data;
    int          exp_cyc;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [17:0] a;
    logic [15:0] d;
    int cyc, pulses, ack_c, rd_c, oe_cnt, we_cnt, n;
    logic [15:0] rdv;

    for (int i = 0; i < 262144; i++) begin
      sram_mem[i] = fill(18'(i));
      gold[i]     = fill(18'(i));
    end
    sram_mem[5] = 16'h1234;
    gold[5]     = 16'h1234;

    vt[0] = '{0, 16'h0005, 6'h00, 18'h00005, 16'h1234, 2};
    vt[1] = '{1, 16'h0000, 6'h0C, 18'h10000, 16'h000C, 3};
    vt[2] = '{1, 16'h0000, 6'h3F, 18'h10001, 16'h003F, 3};
    vt[3] = '{0, 16'h0100, 6'h00, 18'h00100, fill(18'h00100), 2};
    vt[4] = '{1, 16'h0000, 6'h21, 18'h10002, 16'h0021, 3};
    vt[5] = '{0, 16'hFFFF, 6'h00, 18'h0FFFF, fill(18'h0FFFF), 2};
    vt[6] = '{0, 16'h009F, 6'h00, 18'h0009F, fill(18'h0009F), 2};
    vt[7] = '{1, 16'h0000, 6'h00, 18'h10003, 16'h0000, 3};

    m_front = 0; m_ptr = 0; m_full = 0;
    rst = 1'b0; vsync_start = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst ce_n", 32'(sram_ce_n), 1);
    check("rst oe_n", 32'(sram_oe_n), 1);
    check("rst we_n", 32'(sram_we_n), 1);
    check("rst ub_n", 32'(sram_ub_n), 1);
    check("rst lb_n", 32'(sram_lb_n), 1);
    check("rst dq z", 32'(sram_dq === 16'hzzzz), 1);
    check("rst addr", 32'(sram_addr), 0);
    check("rst front", 32'(front_bank), 0);
    check("rst rd_data", 32'(rd_data), 0);
    check("rst pulses", 32'({rd_valid, wr_ack, frame_done}), 0);
    rst = 1'b1;

    // Idle with no requests
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_valid || wr_ack || frame_done) pulses++;
      if (!(sram_ce_n && sram_oe_n && sram_we_n) || sram_dq !== 16'hzzzz) pulses++;
    end
    check("idle quiet", pulses, 0);

    // Vector table from IDLE
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vt[i].is_wr) model_write(vt[i].pix, 1'b0, "tbl", a, d, cyc);
      else             model_read(vt[i].addr, 1'b0, "tbl", d, a, cyc);
      check($sformatf("vec%0d addr", i), 32'(a), 32'(vt[i].exp_addr));
      check($sformatf("vec%0d data", i), 32'(d), 32'(vt[i].exp_data));
      check($sformatf("vec%0d cycles", i), cyc, vt[i].exp_cyc);
    end

    // Contention: read request raised during WR_SETUP
    @(negedge clk);
    wr_req = 1'b1; wr_data = 6'h15;
    @(negedge clk);
    check("setup strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'(5'b01110));
    check("setup dq", 32'(sram_dq), 32'h0015);
    check("setup addr", 32'(sram_addr), 32'h10004);
    rd_req = 1'b1; rd_addr = 16'h0002;
    ack_c = 0; rd_c = 0; oe_cnt = 0; we_cnt = 0; rdv = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (wr_ack) begin ack_c = c; wr_req = 1'b0; end
      if (rd_valid) begin rd_c = c; rdv = rd_data; break; end
    end
    rd_req = 1'b0;
    gold[18'h10004] = 16'h0015; m_ptr = 5;
    check("contention ack cycle", ack_c, 2);
    check("contention rd_valid cycle", rd_c, 5);
    check("contention rd data", 32'(rdv), 32'(gold[18'h00002]));
    check("contention oe cycles", oe_cnt, 1);
    check("contention we cycles", we_cnt, 1);

    // Complete the frame
    n = 0;
    while (!m_full && n < FW + 5) begin
      model_write(6'($urandom), 1'b0, "fill", a, d, cyc);
      n++;
    end
    check("frame filled", 32'(m_full), 1);
    model_write(6'h11, 1'b0, "full", a, d, cyc);
    vsync_pulse("swap1");
    check("front after swap", 32'(front_bank), 1);
    model_write(6'h22, 1'b0, "post swap", a, d, cyc);
    check("first write new back", 32'(a), 32'h00000);

    // Partial frame: vsync ignored
    while (m_ptr < 100) model_write(6'($urandom), 1'b0, "part", a, d, cyc);
    vsync_pulse("noswap");
    check("front no swap", 32'(front_bank), 1);
    model_write(6'h2B, 1'b0, "after noswap", a, d, cyc);
    check("wr_ptr kept", 32'(a), 32'h00064);

    // vsync on the final ack
    while (m_ptr < FW - 1) model_write(6'($urandom), 1'b0, "tofinal", a, d, cyc);
    model_write(6'h3C, 1'b1, "final+vs", a, d, cyc);
    check("front after final swap", 32'(front_bank), 0);
    model_write(6'h05, 1'b0, "after final swap", a, d, cyc);
    check("write after final swap", 32'(a), 32'h10000);

    // Swap requested during RD
    n = 0;
    while (!m_full && n < FW + 5) begin
      model_write(6'($urandom), 1'b0, "fill2", a, d, cyc);
      n++;
    end
    @(negedge clk);
    model_read(16'h0007, 1'b1, "rd+vs", d, a, cyc);
    check("rd+vs old bank addr", 32'(a), 32'h00007);
    check("front after rd swap", 32'(front_bank), 1);
    model_read(16'h0007, 1'b0, "new front", d, a, cyc);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      if (r <= 2)
        model_read(16'($urandom_range(0, FW - 1)), ($urandom_range(0, 7) == 0), "rnd", d, a, cyc);
      else if (r <= 8)
        model_write(6'($urandom), 1'b0, "rnd", a, d, cyc);
      else
        vsync_pulse("rnd");
    end

    // Asynchronous reset during WR_PULSE
    if (m_full) vsync_pulse("pre-reset");
    @(negedge clk);
    wr_req = 1'b1; wr_data = 6'h2A;
    @(negedge clk);
    @(posedge clk);
    #2;
    check("pulse we low", 32'(sram_we_n), 0);
    rst = 1'b0;
    #1;
    check("async rst we_n", 32'(sram_we_n), 1);
    check("async rst ce_n", 32'(sram_ce_n), 1);
    check("async rst dq z", 32'(sram_dq === 16'hzzzz), 1);
    check("async rst front", 32'(front_bank), 0);
    check("async rst ack", 32'(wr_ack), 0);
    wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
